adc_test_sequencer: RTL and testbench

- Controller that steps the RX/ATRP/AR/TXA ADC test chain through a table of rate codes M, one test step per entry.
- Per step: drives M, waits a settle interval, enables TX, waits for the measurement-ready strobe, captures AMP and N_RXPN, and range-checks them.
- Replaces hand-timed M changes in benches and board tests; sits between the top-level control/buttons and the test chain's M/en_TX/res/err/AMP/N_RXPN signals.

---
 rtl/adc_test_sequencer_pkg.sv | 30 +++
 rtl/adc_test_sequencer_step_timer.sv | 28 ++
 rtl/adc_test_sequencer.sv | 163 ++++++++++++++++
 tb/tb_adc_test_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_test_sequencer_pkg.sv
// Shared types and constants for the ADC test sequencer.
// State encoding, failure codes and table geometry.
package adc_test_sequencer_pkg;

    localparam int M_W = 6;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETUP,
        S_SETTLE,
        S_ARM,
        S_WAIT_RES,
        S_CHECK,
        S_NEXT,
        S_FAIL,
        S_DONE
    } state_t;

    localparam logic [1:0] FC_NONE  = 2'd0;
    localparam logic [1:0] FC_ERR   = 2'd1;
    localparam logic [1:0] FC_TMO   = 2'd2;
    localparam logic [1:0] FC_RANGE = 2'd3;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/adc_test_sequencer_step_timer.sv
// Loadable down-counter with a zero flag.
// Shared by the settle and timeout phases, which never overlap.
module step_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/adc_test_sequencer.sv
// Steps the ADC test chain through a table of rate codes,
// timing each measurement and range-checking the result.
module adc_test_sequencer
    import adc_test_sequencer_pkg::*;
#(
    parameter int          N_STEPS     = 6,
    parameter logic [47:0] M_TABLE     = {6'd4, 6'd5, 6'd6,
                                          6'd16, 6'd6, 6'd5},
    parameter int          SETTLE_CYC  = 170000,
    parameter int          TIMEOUT_CYC = 200000,
    parameter logic [10:0] AMP_MIN     = 11'd64,
    parameter logic [10:0] AMP_MAX     = 11'd2000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    input  logic           res,
    input  logic           err,
    input  logic [10:0]    AMP,
    input  logic [7:0]     N_RXPN,
    output logic [M_W-1:0] M,
    output logic           en_TX,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [2:0]     fail_step,
    output logic [1:0]     fail_code,
    output logic [10:0]    amp_cap,
    output logic [7:0]     n_cap
);

    localparam int CW = cnt_width(SETTLE_CYC, TIMEOUT_CYC);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] TMO_LD    = CW'(TIMEOUT_CYC - 1);
    localparam logic [2:0]    LAST_STEP = 3'(N_STEPS - 1);

    state_t        state;
    logic [2:0]    step;
    logic          res_d;
    logic [1:0]    fc_pend;
    logic          tmr_load;
    logic          tmr_dec;
    logic          tmr_zero;
    logic [CW-1:0] tmr_val;
    logic          res_edge;
    logic          in_range;

    assign tmr_load = (state == S_SETUP) || (state == S_ARM);
    assign tmr_val  = (state == S_SETUP) ? SETTLE_LD : TMO_LD;
    assign tmr_dec  = (state == S_SETTLE) || (state == S_WAIT_RES);
    assign res_edge = res & ~res_d;
    assign in_range = (amp_cap >= AMP_MIN) && (amp_cap <= AMP_MAX)
                   && (n_cap != 8'd0);

    step_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            step      <= '0;
            res_d     <= 1'b0;
            fc_pend   <= FC_NONE;
            M         <= '0;
            en_TX     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_step <= '0;
            fail_code <= FC_NONE;
            amp_cap   <= '0;
            n_cap     <= '0;
        end else begin
            res_d <= res;
            if (abort) begin
                state <= S_IDLE;
                en_TX <= 1'b0;
                busy  <= 1'b0;
                done  <= 1'b0;
                pass  <= 1'b0;
                step  <= '0;
            end else begin
                unique case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            state     <= S_SETUP;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                            pass      <= 1'b0;
                            fail_step <= '0;
                            fail_code <= FC_NONE;
                            step      <= '0;
                        end
                    end
                    S_SETUP: begin
                        M     <= M_TABLE[M_W*step +: M_W];
                        en_TX <= 1'b0;
                        state <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (tmr_zero) state <= S_ARM;
                    end
                    S_ARM: begin
                        en_TX <= 1'b1;
                        state <= S_WAIT_RES;
                    end
                    // err beats a res edge; a res edge beats expiry
                    S_WAIT_RES: begin
                        if (err) begin
                            fc_pend <= FC_ERR;
                            state   <= S_FAIL;
                        end else if (res_edge) begin
                            amp_cap <= AMP;
                            n_cap   <= N_RXPN;
                            state   <= S_CHECK;
                        end else if (tmr_zero) begin
                            fc_pend <= FC_TMO;
                            state   <= S_FAIL;
                        end
                    end
                    S_CHECK: begin
                        en_TX <= 1'b0;
                        if (in_range) begin
                            state <= S_NEXT;
                        end else begin
                            fc_pend <= FC_RANGE;
                            state   <= S_FAIL;
                        end
                    end
                    S_NEXT: begin
                        if (step == LAST_STEP) begin
                            state <= S_DONE;
                            pass  <= 1'b1;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            step  <= step + 3'd1;
                            state <= S_SETUP;
                        end
                    end
                    S_FAIL: begin
                        en_TX     <= 1'b0;
                        fail_step <= step;
                        fail_code <= fc_pend;
                        pass      <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_DONE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_test_sequencer.sv
// Self-checking bench for adc_test_sequencer.
// Table of test runs plus hand-written corner sequences.
module tb_adc_test_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        res;
    logic        err;
    logic [10:0] AMP;
    logic [7:0]  N_RXPN;
    logic [5:0]  M;
    logic        en_TX;
    logic        busy;
    logic        done;
    logic        pass;
    logic [2:0]  fail_step;
    logic [1:0]  fail_code;
    logic [10:0] amp_cap;
    logic [7:0]  n_cap;

    int n_chk = 0;
    int n_fail = 0;
    int sb_q[$];
    int exp_m[6] = '{5, 6, 16, 6, 5, 4};

    typedef struct {
        int          bad_step;
        int          bad_kind;
        logic [10:0] bad_amp;
        logic [7:0]  bad_n;
        logic [10:0] good_amp;
        int          dly;
        int          exp_pass;
        int          exp_fstep;
        int          exp_fcode;
        int          exp_amp;
    } vec_t;

    vec_t vecs[8];

    adc_test_sequencer #(
        .SETTLE_CYC  (4),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .res       (res),
        .err       (err),
        .AMP       (AMP),
        .N_RXPN    (N_RXPN),
        .M         (M),
        .en_TX     (en_TX),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_step (fail_step),
        .fail_code (fail_code),
        .amp_cap   (amp_cap),
        .n_cap     (n_cap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_en(input logic val, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (en_TX === val) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_run(input vec_t v, input string tag);
        int  last;
        int  hi;
        bit  ok;
        bit  bad;
        last = (v.bad_kind == 0) ? 5 : v.bad_step;
        for (int i = 0; i <= last; i++) sb_q.push_back(exp_m[i]);
        pulse_start();
        for (int s = 0; s <= last; s++) begin
            wait_en(1'b1, ok);
            chk({tag, "_en_rise"}, int'(ok), 1);
            if (!ok) break;
            if (sb_q.size() > 0) chk({tag, "_m"}, int'(M), sb_q.pop_front());
            bad = (s == v.bad_step);
            if (bad && v.bad_kind == 2) begin
                hi = 1;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (en_TX) hi++;
                    else break;
                end
                // 16 clocks in WAIT_RES plus the FAIL clock
                chk({tag, "_tmo_len"}, hi, 17);
            end else begin
                repeat (v.dly - 1) @(negedge clk);
                AMP    = bad ? v.bad_amp : v.good_amp;
                N_RXPN = bad ? v.bad_n : 8'd20;
                res    = 1'b1;
                if (bad && v.bad_kind == 3) err = 1'b1;
                wait_en(1'b0, ok);
                chk({tag, "_en_fall"}, int'(ok), 1);
                res = 1'b0;
                err = 1'b0;
            end
        end
        wait_done(ok);
        chk({tag, "_done"}, int'(ok), 1);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_en_tx"}, int'(en_TX), 0);
        chk({tag, "_pass"}, int'(pass), v.exp_pass);
        chk({tag, "_fstep"}, int'(fail_step), v.exp_fstep);
        chk({tag, "_fcode"}, int'(fail_code), v.exp_fcode);
        chk({tag, "_amp"}, int'(amp_cap), v.exp_amp);
        chk({tag, "_last_m"}, int'(M), exp_m[last]);
        chk({tag, "_sb_left"}, sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        bit ok;
        vecs[0] = '{-1, 0, 0, 0, 500, 5, 1, 0, 0, 500};
        vecs[1] = '{1, 1, 63, 20, 500, 5, 0, 1, 3, 63};
        vecs[2] = '{-1, 0, 0, 0, 64, 5, 1, 0, 0, 64};
        vecs[3] = '{-1, 0, 0, 0, 2000, 16, 1, 0, 0, 2000};
        vecs[4] = '{4, 1, 2001, 20, 700, 5, 0, 4, 3, 2001};
        vecs[5] = '{5, 1, 500, 0, 900, 5, 0, 5, 3, 500};
        vecs[6] = '{2, 2, 0, 0, 300, 5, 0, 2, 2, 300};
        vecs[7] = '{0, 3, 999, 20, 400, 5, 0, 0, 1, 300};

        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        res    = 1'b0;
        err    = 1'b0;
        AMP    = '0;
        N_RXPN = '0;
        @(negedge clk);
        chk("rst_m", int'(M), 0);
        chk("rst_ctl", int'({en_TX, busy, done, pass}), 0);
        chk("rst_fail", int'({fail_step, fail_code}), 0);
        chk("rst_cap", int'({amp_cap, n_cap}), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            do_run(vecs[i], $sformatf("vec%0d", i));
            @(negedge clk);
        end

        // stale res: high before ARM must not count
        res    = 1'b1;
        AMP    = 11'd111;
        N_RXPN = 8'd20;
        pulse_start();
        wait_en(1'b1, ok);
        chk("stale_en", int'(ok), 1);
        repeat (6) @(negedge clk);
        chk("stale_wait", int'({busy, en_TX}), 3);
        chk("stale_nocap", int'(amp_cap), 300);
        res = 1'b0;
        AMP = 11'd777;
        @(negedge clk);
        res = 1'b1;
        wait_en(1'b0, ok);
        res = 1'b0;
        chk("stale_cap", int'(amp_cap), 777);
        for (int s = 1; s <= 2; s++) begin
            wait_en(1'b1, ok);
            repeat (4) @(negedge clk);
            res = 1'b1;
            wait_en(1'b0, ok);
            res = 1'b0;
        end
        for (int i = 0; i < 50 && M != 6'd6; i++) @(negedge clk);
        chk("abort_m_pre", int'(M), 6);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_ctl", int'({en_TX, busy, done, pass}), 0);
        chk("abort_m", int'(M), 6);
        @(negedge clk);

        // async reset while waiting for res
        pulse_start();
        wait_en(1'b1, ok);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_m", int'(M), 0);
        chk("arst_ctl", int'({en_TX, busy}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_run(vecs[0], "after_rst");

        // start held through DONE restarts after one clock
        start = 1'b1;
        @(negedge clk);
        chk("restart_done", int'(done), 0);
        chk("restart_busy", int'(busy), 1);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
